// File: rtl/regfile_wr_ctrl_16_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_ctrl_16_if
// Brief    : Request handshake between game logic and regfile_wr_ctrl_16.
// Revision : 1.0
// ============================================================================
interface regfile_wr_ctrl_16_if #(
    parameter int AW   = 3,
    parameter int SIZE = 16
);
    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   req_addr;
    logic [SIZE-1:0] req_data;
    logic            req_op;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        output req_op,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        input  req_op,
        output req_ready
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wr_ctrl_16.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wr_ctrl_16
// Brief    : Regfile write controller: clear sweep, then FIFO-buffered writes.
//            Define REGFILE_WR_ADD_EN to enable read-modify-write ADD requests.
// Revision : 1.0
// ============================================================================
module regfile_wr_ctrl_16 #(
    parameter int              SIZE        = 16,
    parameter int              DEPTH       = 8,
    parameter int              FIFO_DEPTH  = 4,
    parameter logic [SIZE-1:0] CLEAR_VALUE = '0
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          clear,
    regfile_wr_ctrl_16_if.slave                req,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_count,
    output logic                               ovf,
    output logic [$clog2(DEPTH)-1:0]           rf_waddr,
    output logic [SIZE-1:0]                    rf_write_data,
    output logic                               rf_write_en,
    output logic [$clog2(DEPTH)-1:0]           rf_raddr,
    input  wire logic [SIZE-1:0]               rf_rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] C_LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [PW:0]   C_FULL_CNT  = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_sweep_addr;
    logic [PW:0]     r_wr_ptr;
    logic [PW:0]     r_rd_ptr;
    logic [AW-1:0]   r_fifo_addr [FIFO_DEPTH];
    logic [SIZE-1:0] r_fifo_data [FIFO_DEPTH];

    logic [PW:0]     w_count;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic [AW-1:0]   w_head_addr;
    logic [SIZE-1:0] w_head_data;
    logic [SIZE-1:0] w_head_wdata;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_empty     = (w_count == '0);
    assign w_full      = (w_count == C_FULL_CNT);
    assign w_head_addr = r_fifo_addr[r_rd_ptr[PW-1:0]];
    assign w_head_data = r_fifo_data[r_rd_ptr[PW-1:0]];

    assign req.req_ready = !w_full && !clear && !rst;
    assign w_push        = req.req_valid && req.req_ready;
    assign w_pop         = (r_state == ST_RUN) && !w_empty && !rst;

`ifdef REGFILE_WR_ADD_EN
    logic            r_fifo_op [FIFO_DEPTH];
    logic            r_ovf;
    logic            w_head_op;
    logic            w_carry;
    logic [SIZE-1:0] w_add_sum;

    // No bypass needed: the previous write commits before this combinational read.
    assign w_head_op            = r_fifo_op[r_rd_ptr[PW-1:0]];
    assign {w_carry, w_add_sum} = {1'b0, rf_rdata} + {1'b0, w_head_data};
    assign w_head_wdata         = w_head_op ? w_add_sum : w_head_data;
    assign rf_raddr             = w_head_addr;
    assign ovf                  = r_ovf;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_op[r_wr_ptr[PW-1:0]] <= req.req_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_ovf <= 1'b0;
        end else if (w_pop && w_head_op && w_carry) begin
            r_ovf <= 1'b1;
        end
    end
`else
    logic w_unused_add;

    assign w_head_wdata = w_head_data;
    assign rf_raddr     = '0;
    assign ovf          = 1'b0;
    assign w_unused_add = ^{req.req_op, rf_rdata};
`endif

    assign busy          = (r_state == ST_CLEAR);
    assign fifo_count    = w_count;
    assign rf_write_en   = !rst && ((r_state == ST_CLEAR) || !w_empty);
    assign rf_waddr      = (r_state == ST_CLEAR) ? r_sweep_addr : w_head_addr;
    assign rf_write_data = (r_state == ST_CLEAR) ? CLEAR_VALUE  : w_head_wdata;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr[PW-1:0]] <= req.req_addr;
            r_fifo_data[r_wr_ptr[PW-1:0]] <= req.req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state      <= ST_CLEAR;
            r_sweep_addr <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
        end else begin
            if (r_state == ST_CLEAR) begin
                if (r_sweep_addr == C_LAST_ADDR) begin
                    r_state      <= ST_RUN;
                    r_sweep_addr <= '0;
                end else begin
                    r_sweep_addr <= r_sweep_addr + 1'b1;
                end
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_ctrl_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wr_ctrl_16
// Brief    : Self-checking bench for regfile_wr_ctrl_16 with a regfile model.
// Revision : 1.0
// ============================================================================
module tb_regfile_wr_ctrl_16;

`ifdef REGFILE_WR_ADD_EN
    localparam bit ADD = 1'b1;
`else
    localparam bit ADD = 1'b0;
`endif
    localparam int FD = 4;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        busy;
    logic [2:0]  fifo_count;
    logic        ovf;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_write_data;
    logic        rf_write_en;
    logic [2:0]  rf_raddr;
    logic [15:0] rf_rdata;

    regfile_wr_ctrl_16_if #(.AW(3), .SIZE(16)) rq ();

    regfile_wr_ctrl_16 dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .req           (rq),
        .busy          (busy),
        .fifo_count    (fifo_count),
        .ovf           (ovf),
        .rf_waddr      (rf_waddr),
        .rf_write_data (rf_write_data),
        .rf_write_en   (rf_write_en),
        .rf_raddr      (rf_raddr),
        .rf_rdata      (rf_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile stand-in: registered write, combinational read.
    logic [15:0] rf_mem [8];
    logic        rf_init;
    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= 16'hA5A5;
        end else if (rf_write_en) begin
            rf_mem[rf_waddr] <= rf_write_data;
        end
    end
    assign rf_rdata = rf_mem[rf_raddr];

    // Reference model: sweep flag/counter, queue of pending requests, memory image.
    typedef struct packed {
        logic        op;
        logic [2:0]  addr;
        logic [15:0] data;
    } req_t;

    req_t        mq[$];
    logic        m_sweep;
    int          m_cnt;
    logic        m_ovf;
    logic [15:0] m_mem [8];

    int n_tests;
    int n_fail;
    bit chk_en;

    logic       s_we, s_ready, s_busy, s_ovf, s_acc;
    logic [2:0] s_waddr, s_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle();
        logic        ex_ready, ex_we, carry;
        logic [2:0]  ex_wa;
        logic [15:0] ex_wd;
        req_t        h;
        #1;
        ex_ready = !rst && !clear && (mq.size() < FD);
        ex_we    = !rst && (m_sweep || mq.size() != 0);
        carry    = 1'b0;
        ex_wa    = '0;
        ex_wd    = '0;
        h        = '0;
        if (m_sweep) begin
            ex_wa = 3'(m_cnt);
            ex_wd = 16'h0000;
        end else if (mq.size() != 0) begin
            h     = mq[0];
            ex_wa = h.addr;
            if (ADD && h.op) {carry, ex_wd} = {1'b0, m_mem[h.addr]} + {1'b0, h.data};
            else             ex_wd = h.data;
        end
        s_we    = rf_write_en;
        s_ready = rq.req_ready;
        s_busy  = busy;
        s_ovf   = ovf;
        s_waddr = rf_waddr;
        s_cnt   = fifo_count;
        s_acc   = ex_ready && rq.req_valid;
        if (chk_en) begin
            chk("req_ready", {31'b0, rq.req_ready}, {31'b0, ex_ready});
            chk("write_en", {31'b0, rf_write_en}, {31'b0, ex_we});
            chk("busy", {31'b0, busy}, {31'b0, m_sweep});
            chk("fifo_count", {29'b0, fifo_count}, mq.size());
            chk("ovf", {31'b0, ovf}, {31'b0, m_ovf});
            if (ex_we) begin
                chk("waddr", {29'b0, rf_waddr}, {29'b0, ex_wa});
                chk("wdata", {16'b0, rf_write_data}, {16'b0, ex_wd});
            end
            if (!ADD) chk("raddr_zero", {29'b0, rf_raddr}, 32'd0);
            else if (!m_sweep && mq.size() != 0 && h.op)
                chk("raddr", {29'b0, rf_raddr}, {29'b0, h.addr});
        end
        if (rst) begin
            m_sweep = 1'b1;
            m_cnt   = 0;
            m_ovf   = 1'b0;
            mq.delete();
        end else begin
            if (ex_we) m_mem[ex_wa] = ex_wd;
            if (m_sweep) begin
                if (m_cnt == 7) begin
                    m_sweep = 1'b0;
                    m_cnt   = 0;
                end else begin
                    m_cnt++;
                end
            end else if (mq.size() != 0) begin
                void'(mq.pop_front());
                if (carry) m_ovf = 1'b1;
            end
            if (s_acc) mq.push_back({rq.req_op, rq.req_addr, rq.req_data});
            if (clear) begin
                mq.delete();
                m_ovf   = 1'b0;
                m_sweep = 1'b1;
                m_cnt   = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic op, input logic [2:0] a, input logic [15:0] d);
        rq.req_valid = v;
        rq.req_op    = op;
        rq.req_addr  = a;
        rq.req_data  = d;
    endtask

    typedef struct {
        logic        op;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [15:0] exp_val;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int n, first, k;
        if (ADD) begin
            tbl[0] = '{1'b0, 3'd3, 16'hBEEF, 16'hBEEF, 1'b0};
            tbl[1] = '{1'b0, 3'd2, 16'hFFF0, 16'hFFF0, 1'b0};
            tbl[2] = '{1'b1, 3'd2, 16'h0020, 16'h0010, 1'b1};
            tbl[3] = '{1'b1, 3'd2, 16'h0001, 16'h0011, 1'b1};
            tbl[4] = '{1'b0, 3'd7, 16'h1234, 16'h1234, 1'b1};
            tbl[5] = '{1'b1, 3'd3, 16'h0001, 16'hBEF0, 1'b1};
        end else begin
            tbl[0] = '{1'b0, 3'd3, 16'hBEEF, 16'hBEEF, 1'b0};
            tbl[1] = '{1'b0, 3'd2, 16'hFFF0, 16'hFFF0, 1'b0};
            tbl[2] = '{1'b1, 3'd2, 16'h0020, 16'h0020, 1'b0};
            tbl[3] = '{1'b1, 3'd2, 16'h0001, 16'h0001, 1'b0};
            tbl[4] = '{1'b0, 3'd7, 16'h1234, 16'h1234, 1'b0};
            tbl[5] = '{1'b1, 3'd3, 16'h0001, 16'h0001, 1'b0};
        end
        n_tests = 0;
        n_fail  = 0;
        chk_en  = 1'b0;
        m_sweep = 1'b1;
        m_cnt   = 0;
        m_ovf   = 1'b0;
        for (int i = 0; i < 8; i++) m_mem[i] = 16'hA5A5;
        rf_init = 1'b1;
        rst     = 1'b1;
        clear   = 1'b0;
        set_req(1'b0, 1'b0, 3'd0, 16'h0);
        @(posedge clk);
        #1;
        rf_init = 1'b0;
        chk_en  = 1'b1;

        // Reset held two cycles, then an 8-cycle sweep over addresses 0..7.
        cycle();
        chk("rst_write_en", {31'b0, s_we}, 32'd0);
        chk("rst_ready", {31'b0, s_ready}, 32'd0);
        chk("rst_count", {29'b0, s_cnt}, 32'd0);
        cycle();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (s_we) begin
                chk("sweep_addr", {29'b0, s_waddr}, n);
                n++;
            end
        end
        chk("sweep_len", n, 8);
        chk("sweep_busy_done", {31'b0, s_busy}, 32'd0);
        for (int i = 0; i < 8; i++) chk("sweep_entry", {16'b0, rf_mem[i]}, 32'd0);

        // Single requests in RUN: write at N+1, readable at N+2.
        for (int i = 0; i < 6; i++) begin
            set_req(1'b1, tbl[i].op, tbl[i].addr, tbl[i].data);
            cycle();
            set_req(1'b0, 1'b0, 3'd0, 16'h0);
            cycle();
            chk("tbl_we_n1", {31'b0, s_we}, 32'd1);
            chk("tbl_waddr_n1", {29'b0, s_waddr}, {29'b0, tbl[i].addr});
            chk("tbl_entry", {16'b0, rf_mem[tbl[i].addr]}, {16'b0, tbl[i].exp_val});
            chk("tbl_ovf", {31'b0, ovf}, {31'b0, tbl[i].exp_ovf});
        end

        // Back-to-back ADDs to one address.
        set_req(1'b1, 1'b0, 3'd5, 16'hFFFF); cycle();
        set_req(1'b1, 1'b1, 3'd5, 16'h0001); cycle();
        set_req(1'b1, 1'b1, 3'd5, 16'h0001); cycle();
        set_req(1'b0, 1'b0, 3'd0, 16'h0);
        cycle();
        cycle();
        chk("b2b_add_entry", {16'b0, rf_mem[5]}, 32'h0001);
        chk("b2b_add_ovf", {31'b0, ovf}, {31'b0, ADD});

        // Clear flushes queued requests and restarts the sweep.
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        chk("clr_ovf", {31'b0, ovf}, 32'd0);
        for (int j = 0; j < 3; j++) begin
            set_req(1'b1, 1'b0, 3'(j + 1), 16'h7001 + 16'(j));
            cycle();
        end
        set_req(1'b0, 1'b0, 3'd0, 16'h0);
        chk("clr_queued", {29'b0, fifo_count}, 32'd3);
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        cycle();
        chk("clr_count", {29'b0, s_cnt}, 32'd0);
        chk("clr_busy", {31'b0, s_busy}, 32'd1);
        chk("clr_restart_addr", {29'b0, s_waddr}, 32'd0);
        repeat (10) cycle();
        for (int j = 1; j <= 3; j++) chk("clr_no_write", {16'b0, rf_mem[j]}, 32'd0);

        // Six requests offered during the sweep: only four fit.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            set_req(1'b1, 1'b0, 3'(k + 1), 16'h1000 + 16'(k));
            cycle();
            if (s_acc) k++;
        end
        chk("full_accepted", k, 4);
        chk("full_ready", {31'b0, s_ready}, 32'd0);
        chk("full_count", {29'b0, s_cnt}, 32'd4);
        for (int i = 0; i < 30 && k < 6; i++) begin
            set_req(1'b1, 1'b0, 3'(k + 1), 16'h1000 + 16'(k));
            cycle();
            if (s_acc) k++;
        end
        chk("full_all_accepted", k, 6);
        set_req(1'b0, 1'b0, 3'd0, 16'h0);
        repeat (6) cycle();
        for (int j = 0; j < 6; j++) chk("full_entry", {16'b0, rf_mem[j + 1]}, 32'h1000 + j);

        // Reset mid-sweep at address 5 abandons it; the next sweep is complete.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (5) cycle();
        cycle();
        chk("midrst_at5", {29'b0, s_waddr}, 32'd5);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n = 0;
        first = 99;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (s_we) begin
                if (n == 0) first = int'(s_waddr);
                n++;
            end
        end
        chk("midrst_first", first, 0);
        chk("midrst_len", n, 8);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) == 0) ? 16'hFFF0 | 16'($urandom_range(0, 15))
                                                : 16'($urandom));
            clear = ($urandom_range(0, 49) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            cycle();
        end
        clear = 1'b0;
        rst   = 1'b0;
        set_req(1'b0, 1'b0, 3'd0, 16'h0);
        repeat (14) cycle();
        for (int i = 0; i < 8; i++) chk("rand_mem", {16'b0, rf_mem[i]}, {16'b0, m_mem[i]});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wr_ctrl_16.md
Name: regfile_wr_ctrl_16

Overview:
Write-side controller sitting directly upstream of the 16-bit, 8-entry two-read-port regfile; it drives the regfile's write port and one of its read ports.
- After reset or a clear request, sweeps every address to a known value.
- Otherwise, buffers write requests from game logic in a small FIFO and retires one per cycle.
- Optionally supports read-modify-write ADD commands, such as score increments.

Parameters:
SIZE, 16, data width; matches regfile entry width
DEPTH, 8, regfile entries; address width AW = $clog2(DEPTH)
FIFO_DEPTH, 4, request buffer entries; power of 2, >= 2
CLEAR_VALUE, 0, value written to every address during a sweep

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
clear  in  1  single-cycle pulse: flush FIFO, restart sweep
req_valid  in  1  request offered
req_ready  out  1  request accepted when req_valid & req_ready
req_addr  in  AW  target address
req_data  in  SIZE  write data or ADD operand
req_op  in  1  0 = WRITE, 1 = ADD (ADD only honoured with the feature below)
busy  out  1  high while sweeping
fifo_count  out  $clog2(FIFO_DEPTH)+1  queued requests
ovf  out  1  sticky ADD carry-out flag
rf_waddr  out  AW  to regfile waddr
rf_write_data  out  SIZE  to regfile write_data
rf_write_en  out  1  to regfile write_en
rf_raddr  out  AW  to regfile raddr1
rf_rdata  in  SIZE  from regfile read_data1 (combinational read)

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. All state updates on posedge clk.
- Reset values: state = CLEAR, sweep_addr = 0, FIFO empty, fifo_count = 0, ovf = 0.
- While rst is high: rf_write_en = 0, req_ready = 0.
- rf_* outputs are combinational from state and FIFO head; the regfile registers the write.
- State CLEAR:
  - rf_write_en = 1, rf_waddr = sweep_addr, rf_write_data = CLEAR_VALUE; busy = 1.
  - sweep_addr increments each cycle.
  - When sweep_addr = DEPTH-1, go to RUN and wrap sweep_addr to 0.
  - Sweep takes exactly DEPTH cycles after rst deasserts.
- State RUN:
  - busy = 0.
  - If FIFO is non-empty: pop head, rf_write_en = 1, rf_waddr = head.addr.
  - WRITE: rf_write_data = head.data.
  - If FIFO is empty: rf_write_en = 0; rf_waddr and rf_write_data hold the head-slot contents (don't-care).
- Handshake:
  - req_ready = !full & !clear & !rst, in both states.
  - Requests accepted during CLEAR queue up and retire after the sweep, in order.
  - Full FIFO: no push, even if a pop occurs in the same cycle.
  - Not full: push and pop in the same cycle are allowed; fifo_count is unchanged.
- Latency: accepted in cycle N with FIFO empty in RUN → rf_write_en high in N+1 → value readable from the regfile in N+2.
- Retire rate: one request per cycle. Retire order equals accept order.
- clear:
  - Takes effect next cycle: FIFO flushed, fifo_count = 0, ovf = 0, state = CLEAR, sweep_addr = 0.
  - Valid in any state; clear during CLEAR restarts the sweep from 0.
  - The regfile write on the cycle clear is high still occurs.
- rst mid-sweep or mid-run: identical to the reset values; the partial sweep is abandoned.
- FIFO pointers are AW-independent, wrap modulo FIFO_DEPTH, and carry an extra bit for the full/empty distinction.

Optional Feature:
Macro REGFILE_WR_ADD_EN.
- Defined:
  - ADD at head: rf_raddr = head.addr, rf_write_data = (rf_rdata + head.data) truncated to SIZE.
  - ovf sets on carry-out and stays sticky until rst or clear.
  - Back-to-back ADDs to the same address are correct without bypass, because the prior write commits at the edge before the next combinational read.
- Not defined:
  - req_op is ignored and every request is treated as WRITE.
  - rf_raddr = 0; ovf = 0 constant.

Test Plan:
1. rst high 2 cycles then low → rf_write_en high exactly 8 cycles, rf_waddr 0..7, data 0x0000, busy 1 then 0; all regfile entries read 0.
2. After sweep, push WRITE addr 3 data 0xBEEF in cycle N → rf_write_en=1, rf_waddr=3 in N+1; read_data0 with raddr0=3 = 0xBEEF in N+2.
3. Hold req_valid during sweep with 6 distinct requests → 4 accepted, req_ready drops, fifo_count=4; after sweep, 4 writes retire in order in consecutive cycles; the remaining 2 are then accepted.
4. (ADD_EN) WRITE addr 2 = 0xFFF0, then ADD addr 2 0x0020 → entry = 0x0010, ovf=1; then ADD addr 2 0x0001 twice back-to-back → 0x0012.
5. 3 requests queued, pulse clear → fifo_count=0 next cycle, ovf=0, 8-cycle sweep restarts at addr 0, queued writes never appear.
6. Assert rst for 1 cycle while sweep_addr=5 → next sweep starts at addr 0 and runs the full 8 cycles.
